// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the DAC frame scheduler.
package dac_sched_pkg;

    typedef enum logic [2:0] {
        ST_DELAY,
        ST_INIT,
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } sched_state_e;

    localparam logic [7:0]  CH_LEFT         = 8'h31;
    localparam logic [7:0]  CH_RIGHT        = 8'h32;
    localparam logic [23:0] INIT_WORD_0_DEF = 24'h280001;
    localparam logic [23:0] INIT_WORD_1_DEF = 24'h380001;

endpackage

// File: rtl/dac_frame_timer.sv
// Sample-rate divider plus frame busy tracking and sticky overrun detection.
module dac_frame_timer
    import dac_sched_pkg::*;
#(
    parameter logic [15:0] SAMPLE_DIV = 16'd1250
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable_i,
    input  logic frame_done_i,
    output logic start_o,
    output logic overrun_o
);

    logic [15:0] cnt_q, cnt_d;
    logic        start_q, start_d;
    logic        busy_q, busy_d;
    logic        overrun_q, overrun_d;

    always_comb begin
        cnt_d     = cnt_q;
        start_d   = 1'b0;
        busy_d    = busy_q;
        overrun_d = overrun_q;
        if (enable_i) begin
            if (cnt_q == SAMPLE_DIV - 16'd1) begin
                cnt_d   = '0;
                start_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
        if (frame_done_i) begin
            busy_d = 1'b0;
        end
        // A frame finishing on the strobe cycle is on time, not an overrun.
        if (start_q) begin
            busy_d = 1'b1;
            if (busy_q && !frame_done_i) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign start_o   = start_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/dac_frame_scheduler.sv
// Arbitrates the shared DAC serializer between init words, L/R sample pairs and config words.
// Define DAC_SCHED_WATCHDOG_EN to add the transfer watchdog and the o_Fault port.
module dac_frame_scheduler
    import dac_sched_pkg::*;
#(
    parameter logic [15:0] SAMPLE_DIV  = 16'd1250,
    parameter logic [15:0] INIT_DELAY  = 16'd4000,
    parameter logic [23:0] INIT_WORD_0 = INIT_WORD_0_DEF,
    parameter logic [23:0] INIT_WORD_1 = INIT_WORD_1_DEF
) (
    input  logic        i_Clock,
    input  logic        i_Reset_N,
    input  logic        i_Smp_Valid,
    input  logic [23:0] i_Smp_Data,
    input  logic        i_Smp_Last,
    output logic        o_Smp_Ack,
    input  logic        i_Cfg_Valid,
    input  logic [23:0] i_Cfg_Data,
    output logic        o_Cfg_Ack,
    output logic        o_Sample_Start,
    output logic [23:0] o_DAC_Data,
    output logic        o_DAC_Send,
    input  logic        i_DAC_Ready,
    output logic        o_Init_Done,
    output logic        o_Overrun
`ifdef DAC_SCHED_WATCHDOG_EN
    ,
    output logic        o_Fault
`endif
);

    sched_state_e state_q, state_d;
    logic [15:0]  delay_q, delay_d;
    logic         idx_q, idx_d;
    logic [23:0]  data_q, data_d;
    logic         lock_q, lock_d;
    logic         last_q, last_d;
    logic         init_done_q, init_done_d;
    logic         frame_done;
`ifdef DAC_SCHED_WATCHDOG_EN
    logic [9:0]   wd_q, wd_d;
    logic         fault_q, fault_d;
`endif

    always_comb begin
        state_d     = state_q;
        delay_d     = delay_q;
        idx_d       = idx_q;
        data_d      = data_q;
        lock_d      = lock_q;
        last_d      = last_q;
        init_done_d = init_done_q;
        o_Smp_Ack   = 1'b0;
        o_Cfg_Ack   = 1'b0;
        frame_done  = 1'b0;
        case (state_q)
            ST_DELAY: begin
                if (delay_q == INIT_DELAY - 16'd1) begin
                    state_d = ST_INIT;
                end else begin
                    delay_d = delay_q + 16'd1;
                end
            end
            ST_INIT: begin
                if (i_DAC_Ready) begin
                    data_d  = idx_q ? INIT_WORD_1 : INIT_WORD_0;
                    last_d  = 1'b0;
                    state_d = ST_SEND;
                end
            end
            ST_IDLE: begin
                // While the frame lock is held only the pending R word may win.
                if (i_DAC_Ready && init_done_q) begin
                    if (i_Smp_Valid) begin
                        o_Smp_Ack = 1'b1;
                        data_d    = i_Smp_Data;
                        last_d    = i_Smp_Last;
                        lock_d    = !i_Smp_Last;
                        state_d   = ST_SEND;
                    end else if (i_Cfg_Valid && !lock_q) begin
                        o_Cfg_Ack = 1'b1;
                        data_d    = i_Cfg_Data;
                        last_d    = 1'b0;
                        state_d   = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (!i_DAC_Ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_DAC_Ready) begin
                    state_d = ST_IDLE;
                    if (!init_done_q) begin
                        if (!idx_q) begin
                            idx_d   = 1'b1;
                            state_d = ST_INIT;
                        end else begin
                            init_done_d = 1'b1;
                        end
                    end else begin
                        frame_done = last_q;
                    end
                end
            end
            default: state_d = ST_DELAY;
        endcase
`ifdef DAC_SCHED_WATCHDOG_EN
        wd_d    = '0;
        fault_d = fault_q;
        if (state_q == ST_SEND || state_q == ST_DONE) begin
            wd_d = wd_q + 10'd1;
            if (wd_q == 10'd1023) begin
                wd_d    = '0;
                state_d = ST_IDLE;
                lock_d  = 1'b0;
                fault_d = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            state_q     <= ST_DELAY;
            delay_q     <= '0;
            idx_q       <= 1'b0;
            data_q      <= '0;
            lock_q      <= 1'b0;
            last_q      <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            delay_q     <= delay_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            lock_q      <= lock_d;
            last_q      <= last_d;
            init_done_q <= init_done_d;
        end
    end

`ifdef DAC_SCHED_WATCHDOG_EN
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            wd_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            fault_q <= fault_d;
        end
    end

    assign o_Fault = fault_q;
`endif

    dac_frame_timer #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_timer (
        .clk_i       (i_Clock),
        .rst_ni      (i_Reset_N),
        .enable_i    (init_done_q),
        .frame_done_i(frame_done),
        .start_o     (o_Sample_Start),
        .overrun_o   (o_Overrun)
    );

    assign o_DAC_Send  = (state_q == ST_SEND);
    assign o_DAC_Data  = data_q;
    assign o_Init_Done = init_done_q;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Scoreboard bench: a serializer model pops expected words; a monitor logs acks, strobes and latency.
`timescale 1ns/1ps
module tb_dac_frame_scheduler;
    import dac_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        smp_valid = 1'b0;
    logic [23:0] smp_data = '0;
    logic        smp_last = 1'b0;
    logic        smp_ack;
    logic        cfg_valid = 1'b0;
    logic [23:0] cfg_data = '0;
    logic        cfg_ack;
    logic        start;
    logic [23:0] dac_data;
    logic        dac_send;
    logic        dac_ready;
    logic        init_done;
    logic        overrun;
`ifdef DAC_SCHED_WATCHDOG_EN
    logic        fault;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dac_frame_scheduler #(
        .SAMPLE_DIV(16'd100),
        .INIT_DELAY(16'd20)
    ) dut (
        .i_Clock       (clk),
        .i_Reset_N     (rst_n),
        .i_Smp_Valid   (smp_valid),
        .i_Smp_Data    (smp_data),
        .i_Smp_Last    (smp_last),
        .o_Smp_Ack     (smp_ack),
        .i_Cfg_Valid   (cfg_valid),
        .i_Cfg_Data    (cfg_data),
        .o_Cfg_Ack     (cfg_ack),
        .o_Sample_Start(start),
        .o_DAC_Data    (dac_data),
        .o_DAC_Send    (dac_send),
        .i_DAC_Ready   (dac_ready),
        .o_Init_Done   (init_done),
        .o_Overrun     (overrun)
`ifdef DAC_SCHED_WATCHDOG_EN
        ,
        .o_Fault       (fault)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Serializer model: Ready drops 2 clocks after Send is seen, returns busy_len clocks later.
    logic [23:0] exp_q[$];
    int busy_len = 50;
    int words_seen = 0;
    int ready_rise_cyc = -1;
    initial begin
        dac_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (dac_send && dac_ready) begin
                words_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", dac_data);
                end else begin
                    check("dac_word", dac_data, exp_q.pop_front());
                end
                repeat (2) @(negedge clk);
                dac_ready = 1'b0;
                repeat (busy_len) @(negedge clk);
                dac_ready = 1'b1;
                ready_rise_cyc = cyc;
            end
        end
    end

    // Monitor: logs events and checks grant-to-send latency.
    int start_cyc[$];
    int smp_ack_cyc[$];
    int cfg_ack_cyc[$];
    int done_cyc = -1;
    int ack_in_init = 0;
    logic prev_ack = 1'b0;
    logic prev_done = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (prev_ack) check("grant_to_send", dac_send, 1);
            prev_ack = smp_ack | cfg_ack;
            if ((smp_ack || cfg_ack) && !init_done) ack_in_init++;
            if (smp_ack) smp_ack_cyc.push_back(cyc);
            if (cfg_ack) cfg_ack_cyc.push_back(cyc);
            if (start) start_cyc.push_back(cyc);
            if (init_done && !prev_done) done_cyc = cyc;
            prev_done = init_done;
        end
    end

    task automatic send_smp(input logic [23:0] d, input logic last);
        bit ok = 0;
        smp_valid = 1'b1;
        smp_data  = d;
        smp_last  = last;
        for (int i = 0; i < 2000; i++) begin
            #1;
            if (smp_ack) begin
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        smp_valid = 1'b0;
        check("smp_ack_seen", int'(ok), 1);
    endtask

    task automatic send_cfg(input logic [23:0] d);
        bit ok = 0;
        cfg_valid = 1'b1;
        cfg_data  = d;
        for (int i = 0; i < 2000; i++) begin
            #1;
            if (cfg_ack) begin
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        check("cfg_ack_seen", int'(ok), 1);
    endtask

    task automatic wait_starts(input int n);
        for (int i = 0; i < 400 && start_cyc.size() < n; i++) @(negedge clk);
        check("start_seen", int'(start_cyc.size() >= n), 1);
    endtask

    task automatic wait_idle();
        int i = 0;
        while (i < 3000 && !(exp_q.size() == 0 && dac_ready && !dac_send)) begin
            @(negedge clk);
            i++;
        end
        check("idle_reached", int'(i < 3000), 1);
    endtask

    task automatic wait_init();
        for (int i = 0; i < 1000 && !init_done; i++) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_send", dac_send, 0);
        check("rst_data", dac_data, 0);
        check("rst_init_done", init_done, 0);
        check("rst_start", start, 0);
        check("rst_overrun", overrun, 0);
        check("rst_acks", int'(smp_ack | cfg_ack), 0);

        // Init sequence; requests held high must be ignored until init completes.
        exp_q.push_back(24'h280001);
        exp_q.push_back(24'h380001);
        rst_n     = 1'b1;
        smp_valid = 1'b1;
        smp_data  = 24'h31FFFF;
        smp_last  = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 24'h4F0000;
        wait_init();
        smp_valid = 1'b0;
        cfg_valid = 1'b0;
        #3;
        check("init_done_rise", init_done, 1);
        check("init_words_left", exp_q.size(), 0);
        check("init_words_seen", words_seen, 2);
        check("init_done_after_ready", done_cyc, ready_rise_cyc + 1);
        check("no_ack_in_init", ack_in_init, 0);
        busy_len = 10;

        // First strobe 100 clocks after init, then an L/R pair with config raised in between.
        wait_starts(1);
        check("first_start_latency", start_cyc[0] - done_cyc, 100);
        exp_q.push_back(24'h31ABCD);
        exp_q.push_back(24'h321234);
        exp_q.push_back(24'h400000);
        send_smp(24'h31ABCD, 1'b0);
        fork
            send_cfg(24'h400000);
            begin
                repeat (5) @(negedge clk);
                send_smp(24'h321234, 1'b1);
            end
        join
        check("cfg_after_r_word", int'(cfg_ack_cyc[$] > smp_ack_cyc[$]), 1);
        wait_idle();

        // Both ports valid in the same idle cycle.
        wait_starts(2);
        check("start_period_1", start_cyc[1] - start_cyc[0], 100);
        check("no_overrun_1", overrun, 0);
        exp_q.push_back(24'h31AAAA);
        exp_q.push_back(24'h325555);
        exp_q.push_back(24'h4000FF);
        n = smp_ack_cyc.size();
        fork
            begin
                send_smp(24'h31AAAA, 1'b0);
                send_smp(24'h325555, 1'b1);
            end
            send_cfg(24'h4000FF);
        join
        check("smp_acks_in_pair", smp_ack_cyc.size() - n, 2);
        check("cfg_after_pair", int'(cfg_ack_cyc[$] > smp_ack_cyc[$]), 1);
        wait_idle();

        // Slow serializer: the frame spans strobes and overrun latches.
        wait_starts(3);
        check("start_period_2", start_cyc[2] - start_cyc[1], 100);
        check("no_overrun_2", overrun, 0);
        busy_len = 150;
        exp_q.push_back(24'h31DEAD);
        exp_q.push_back(24'h32BEEF);
        send_smp(24'h31DEAD, 1'b0);
        wait_starts(4);
        @(negedge clk);
        check("start_period_3", start_cyc[3] - start_cyc[2], 100);
        check("overrun_set", overrun, 1);
        send_smp(24'h32BEEF, 1'b1);
        wait_starts(5);
        @(negedge clk);
        check("start_period_4", start_cyc[4] - start_cyc[3], 100);
        check("overrun_sticky", overrun, 1);
        wait_idle();
        check("overrun_still_set", overrun, 1);

        // Reset in the middle of a config transfer reruns init.
        busy_len = 50;
        exp_q.push_back(24'h4ABCDE);
        n = words_seen;
        send_cfg(24'h4ABCDE);
        for (int i = 0; i < 50 && words_seen == n; i++) @(negedge clk);
        check("cfg_word_captured", words_seen, n + 1);
        @(posedge clk);
        #2;
        check("send_before_reset", dac_send, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_send", dac_send, 0);
        check("rst_async_init_done", init_done, 0);
        check("rst_async_overrun", overrun, 0);
        exp_q.push_back(24'h280001);
        exp_q.push_back(24'h380001);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_init();
        #3;
        check("reinit_done", init_done, 1);
        check("reinit_words_left", exp_q.size(), 0);
        check("reinit_words_seen", words_seen, n + 3);
        check("no_ack_in_init_end", ack_in_init, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
